digit_serial_adder: RTL

Multi-cycle wide adder that adds two `4*NIBBLES`-bit operands one nibble per clock, least-significant nibble first. It uses a single instance of the team's `Look_Ahead_Carry_Generator_4_Bit` slice as its datapath and registers the slice carry between nibbles. It sits directly around that slice: it feeds it operand nibbles and a carry, and consumes its `Sum_Out`/`Carry_Out`. It provides wide addition at the area cost of one 4-bit slice.

---
 rtl/digit_serial_adder.sv | 94 +++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: W-bit adder computed one nibble per clock through one 4-bit look-ahead slice
module Look_Ahead_Carry_Generator_4_Bit (
  input  logic [3:0] A_In,
  input  logic [3:0] B_In,
  input  logic       Carry_In,
  output logic [3:0] Sum_Out,
  output logic       Carry_Out
);
  logic [3:0] p, g;
  logic [4:0] c;
  assign p = A_In ^ B_In;
  assign g = A_In & B_In;
  assign c[0] = Carry_In;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign Sum_Out   = p ^ c[3:0];
  assign Carry_Out = c[4];
endmodule

module digit_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 Clock_In,
  input  logic                 Reset_n_In,
  input  logic                 Start_In,
  input  logic [4*NIBBLES-1:0] Data_A_In,
  input  logic [4*NIBBLES-1:0] Data_B_In,
  input  logic                 Carry_In,
  output logic                 Busy_Out,
  output logic                 Done_Out,
  output logic [4*NIBBLES-1:0] Sum_Out,
  output logic                 Carry_Out
);
  localparam int W = 4 * NIBBLES;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st_q, st_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d, acc_nx;
  logic [4:0] cnt_q, cnt_d;
  logic c_q, c_d, co_q, co_d, busy_q, busy_d, done_q, done_d;
  logic [3:0] s_nib;
  logic s_c, ld, run, fin;
  Look_Ahead_Carry_Generator_4_Bit u_slice (
    .A_In(a_q[3:0]), .B_In(b_q[3:0]), .Carry_In(c_q), .Sum_Out(s_nib), .Carry_Out(s_c)
  );
  // new sum nibble enters at the top while the accumulator shifts down
  assign acc_nx = W'({s_nib, acc_q} >> 4);
  always_comb begin
    ld     = (st_q == IDLE) && Start_In;
    run    = st_q == RUN;
    fin    = run && (cnt_q == 5'(NIBBLES - 1));
    st_d   = ld ? RUN : fin ? DONE : (st_q == DONE) ? IDLE : st_q;
    a_d    = ld ? Data_A_In : run ? a_q >> 4 : a_q;
    b_d    = ld ? Data_B_In : run ? b_q >> 4 : b_q;
    c_d    = ld ? Carry_In : run ? s_c : c_q;
    cnt_d  = ld ? 5'd0 : run ? cnt_q + 5'd1 : cnt_q;
    acc_d  = run ? acc_nx : acc_q;
    sum_d  = fin ? acc_nx : sum_q;
    co_d   = fin ? s_c : co_q;
    busy_d = st_d != IDLE;
    done_d = st_d == DONE;
  end
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      st_q   <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      co_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      co_q   <= co_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign Busy_Out  = busy_q;
  assign Done_Out  = done_q;
  assign Sum_Out   = sum_q;
  assign Carry_Out = co_q;
endmodule
